mdu_sched: RTL and testbench

//   Multiply/divide unit scheduler for the 5-stage MIPS pipeline. It sequences
//   the E-stage HI/LO datapath and owns the HI/LO registers. Multi-cycle busy

---
 rtl/mdu_sched.sv | 149 ++++++++++++++
 tb/tb_mdu_sched.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/mdu_sched.sv
// Multiply/divide scheduler for the E stage: owns HI/LO, times multi-cycle ops, raises the D-stage stall.
// Optional MADD/MADDU accumulate support is compiled in when MDU_MADD_EN is defined.
module mdu_sched #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        req,
  input  logic        md_use_d,
  output logic        busy,
  output logic        stall_md,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic [31:0]   hi_pend, lo_pend;
  logic          wr_pend;

  logic is_mult, is_multu, is_div, is_divu, is_mthi, is_mtlo, is_madd, is_maddu;
  logic accept, start_mc, done;

  assign is_mult  = (md_op == 4'd1);
  assign is_multu = (md_op == 4'd2);
  assign is_div   = (md_op == 4'd3);
  assign is_divu  = (md_op == 4'd4);
  assign is_mthi  = (md_op == 4'd5);
  assign is_mtlo  = (md_op == 4'd6);
`ifdef MDU_MADD_EN
  assign is_madd  = (md_op == 4'd7);
  assign is_maddu = (md_op == 4'd8);
`else
  assign is_madd  = 1'b0;
  assign is_maddu = 1'b0;
`endif

  // An op is only taken from E when no exception squashes it and nothing is in flight.
  assign accept   = start & ~req & (state == IDLE);
  assign start_mc = accept & (is_mult | is_multu | is_div | is_divu | is_madd | is_maddu);
  assign busy     = (state == BUSY);
  assign done     = (state == BUSY) && (cnt == CW'(1));
  assign stall_md = md_use_d & (busy | start_mc);

  // Sign-extending to 64 bits lets one unsigned multiplier produce the signed product mod 2^64.
  logic [63:0] prod_s, prod_u;
  assign prod_s = {{32{rs_val[31]}}, rs_val} * {{32{rt_val[31]}}, rt_val};
  assign prod_u = {32'b0, rs_val} * {32'b0, rt_val};

  // Divisors are forced to 1 in the special cases so the dividers never see x/0 or overflow.
  logic        div_zero, div_ovf;
  logic [31:0] divisor_s, divisor_u, q_s, r_s, q_u, r_u;
  assign div_zero  = (rt_val == 32'd0);
  assign div_ovf   = (rs_val == 32'h8000_0000) && (rt_val == 32'hFFFF_FFFF);
  assign divisor_s = (div_zero | div_ovf) ? 32'd1 : rt_val;
  assign divisor_u = div_zero ? 32'd1 : rt_val;
  assign q_s       = 32'($signed(rs_val) / $signed(divisor_s));
  assign r_s       = 32'($signed(rs_val) % $signed(divisor_s));
  assign q_u       = rs_val / divisor_u;
  assign r_u       = rs_val % divisor_u;

  logic [31:0] res_hi, res_lo;
  logic        res_wr;

  always_comb begin
    res_hi = hi;
    res_lo = lo;
    res_wr = 1'b1;
    if (is_mult) begin
      {res_hi, res_lo} = prod_s;
    end else if (is_multu) begin
      {res_hi, res_lo} = prod_u;
    end else if (is_div) begin
      if (div_zero) begin
        res_wr = 1'b0;
      end else if (div_ovf) begin
        res_hi = 32'd0;
        res_lo = 32'h8000_0000;
      end else begin
        res_hi = r_s;
        res_lo = q_s;
      end
    end else if (is_divu) begin
      if (div_zero) begin
        res_wr = 1'b0;
      end else begin
        res_hi = r_u;
        res_lo = q_u;
      end
    end else if (is_madd) begin
      {res_hi, res_lo} = {hi, lo} + prod_s;
    end else if (is_maddu) begin
      {res_hi, res_lo} = {hi, lo} + prod_u;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_mc) state_nxt = BUSY;
      BUSY:    if (cnt == CW'(1)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Results are captured at the start edge and only retired into HI/LO on the last busy cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt     <= '0;
      hi_pend <= '0;
      lo_pend <= '0;
      wr_pend <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      if (start_mc) begin
        cnt     <= (is_div | is_divu) ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
        hi_pend <= res_hi;
        lo_pend <= res_lo;
        wr_pend <= res_wr;
      end else if (state == BUSY) begin
        cnt <= cnt - CW'(1);
      end
      if (done && wr_pend) begin
        hi <= hi_pend;
        lo <= lo_pend;
      end else begin
        if (accept && is_mthi) hi <= rs_val;
        if (accept && is_mtlo) lo <= rs_val;
      end
    end
  end

endmodule

// File: tb/tb_mdu_sched.sv
// Directed self-checking bench for mdu_sched; MADD expectations follow MDU_MADD_EN.
module tb_mdu_sched;

  logic        clk = 1'b0;
  logic        reset, start, req, md_use_d;
  logic [3:0]  md_op;
  logic [31:0] rs_val, rt_val;
  logic        busy, stall_md;
  logic [31:0] hi, lo;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  mdu_sched #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .md_op(md_op),
    .rs_val(rs_val), .rt_val(rt_val), .req(req), .md_use_d(md_use_d),
    .busy(busy), .stall_md(stall_md), .hi(hi), .lo(lo)
  );

  task automatic step;
    @(posedge clk); #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic r);
    md_op = op; rs_val = a; rt_val = b; req = r; start = 1'b1;
    step();
    start = 1'b0; req = 1'b0; md_op = 4'd0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy === 1'b1 && n < 50) begin
      n++;
      step();
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; req = 1'b0; md_use_d = 1'b0;
    md_op = 4'd0; rs_val = '0; rt_val = '0;
    step(); step();
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    tests_run++; if (stall_md !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_stall: got %b expected 0", stall_md); end
    tests_run++; if (hi !== 32'h0) begin tests_failed++; $display("[TB] FAIL reset_hi: got %h expected 00000000", hi); end
    tests_run++; if (lo !== 32'h0) begin tests_failed++; $display("[TB] FAIL reset_lo: got %h expected 00000000", lo); end
    reset = 1'b0;
    step();
  endtask

  task automatic test_async_reset;
    issue(4'd5, 32'hA5A5_A5A5, 32'h0, 1'b0);
    issue(4'd6, 32'h5A5A_5A5A, 32'h0, 1'b0);
    tests_run++; if (hi !== 32'hA5A5_A5A5) begin tests_failed++; $display("[TB] FAIL mthi_load: got %h expected a5a5a5a5", hi); end
    issue(4'd3, 32'd100, 32'd7, 1'b0);
    step(); step();
    #2 reset = 1'b1;
    #1;
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL async_reset_busy: got %b expected 0", busy); end
    tests_run++; if (hi !== 32'h0) begin tests_failed++; $display("[TB] FAIL async_reset_hi: got %h expected 00000000", hi); end
    tests_run++; if (lo !== 32'h0) begin tests_failed++; $display("[TB] FAIL async_reset_lo: got %h expected 00000000", lo); end
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic test_mult;
    int n;
    issue(4'd1, 32'hFFFF_FFFE, 32'd3, 1'b0);
    wait_idle(n);
    tests_run++; if (n !== 5) begin tests_failed++; $display("[TB] FAIL mult_busy_cycles: got %0d expected 5", n); end
    tests_run++; if (hi !== 32'hFFFF_FFFF) begin tests_failed++; $display("[TB] FAIL mult_hi: got %h expected ffffffff", hi); end
    tests_run++; if (lo !== 32'hFFFF_FFFA) begin tests_failed++; $display("[TB] FAIL mult_lo: got %h expected fffffffa", lo); end
    issue(4'd2, 32'hFFFF_FFFE, 32'd3, 1'b0);
    req = 1'b1;
    wait_idle(n);
    req = 1'b0;
    tests_run++; if (n !== 5) begin tests_failed++; $display("[TB] FAIL multu_busy_cycles: got %0d expected 5", n); end
    tests_run++; if (hi !== 32'h0000_0002) begin tests_failed++; $display("[TB] FAIL multu_hi: got %h expected 00000002", hi); end
    tests_run++; if (lo !== 32'hFFFF_FFFA) begin tests_failed++; $display("[TB] FAIL multu_lo: got %h expected fffffffa", lo); end
  endtask

  task automatic test_div;
    int n;
    issue(4'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
    wait_idle(n);
    tests_run++; if (n !== 10) begin tests_failed++; $display("[TB] FAIL div_busy_cycles: got %0d expected 10", n); end
    tests_run++; if (lo !== 32'hFFFF_FFFD) begin tests_failed++; $display("[TB] FAIL div_lo: got %h expected fffffffd", lo); end
    tests_run++; if (hi !== 32'hFFFF_FFFF) begin tests_failed++; $display("[TB] FAIL div_hi: got %h expected ffffffff", hi); end
    issue(4'd3, 32'd5, 32'd0, 1'b0);
    wait_idle(n);
    tests_run++; if (n !== 10) begin tests_failed++; $display("[TB] FAIL divzero_busy_cycles: got %0d expected 10", n); end
    tests_run++; if (lo !== 32'hFFFF_FFFD) begin tests_failed++; $display("[TB] FAIL divzero_lo: got %h expected fffffffd", lo); end
    tests_run++; if (hi !== 32'hFFFF_FFFF) begin tests_failed++; $display("[TB] FAIL divzero_hi: got %h expected ffffffff", hi); end
    issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    wait_idle(n);
    tests_run++; if (lo !== 32'h8000_0000) begin tests_failed++; $display("[TB] FAIL divovf_lo: got %h expected 80000000", lo); end
    tests_run++; if (hi !== 32'h0) begin tests_failed++; $display("[TB] FAIL divovf_hi: got %h expected 00000000", hi); end
    issue(4'd3, 32'd7, 32'hFFFF_FFFE, 1'b0);
    wait_idle(n);
    tests_run++; if (lo !== 32'hFFFF_FFFD) begin tests_failed++; $display("[TB] FAIL divneg_lo: got %h expected fffffffd", lo); end
    tests_run++; if (hi !== 32'h0000_0001) begin tests_failed++; $display("[TB] FAIL divneg_hi: got %h expected 00000001", hi); end
    issue(4'd4, 32'hFFFF_FFFF, 32'd2, 1'b0);
    wait_idle(n);
    tests_run++; if (n !== 10) begin tests_failed++; $display("[TB] FAIL divu_busy_cycles: got %0d expected 10", n); end
    tests_run++; if (lo !== 32'h7FFF_FFFF) begin tests_failed++; $display("[TB] FAIL divu_lo: got %h expected 7fffffff", lo); end
    tests_run++; if (hi !== 32'h0000_0001) begin tests_failed++; $display("[TB] FAIL divu_hi: got %h expected 00000001", hi); end
  endtask

  task automatic test_stall;
    int  n;
    logic seen;
    md_use_d = 1'b1; md_op = 4'd1; rs_val = 32'd2; rt_val = 32'd3; start = 1'b1;
    #1;
    tests_run++; if (stall_md !== 1'b1) begin tests_failed++; $display("[TB] FAIL stall_start_cycle: got %b expected 1", stall_md); end
    @(posedge clk); #1;
    start = 1'b0; md_op = 4'd0;
    n = 0;
    while (stall_md === 1'b1 && n < 50) begin
      n++;
      step();
    end
    tests_run++; if (n !== 5) begin tests_failed++; $display("[TB] FAIL stall_busy_cycles: got %0d expected 5", n); end
    tests_run++; if (lo !== 32'd6) begin tests_failed++; $display("[TB] FAIL stall_mult_lo: got %h expected 00000006", lo); end
    md_use_d = 1'b0;
    issue(4'd1, 32'd4, 32'd4, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      seen = seen | stall_md;
      step();
    end
    tests_run++; if (seen !== 1'b0) begin tests_failed++; $display("[TB] FAIL stall_no_use: got %b expected 0", seen); end
    md_use_d = 1'b1; md_op = 4'd3; rs_val = 32'd9; rt_val = 32'd3; req = 1'b1; start = 1'b1;
    #1;
    tests_run++; if (stall_md !== 1'b0) begin tests_failed++; $display("[TB] FAIL stall_squashed: got %b expected 0", stall_md); end
    @(posedge clk); #1;
    start = 1'b0; req = 1'b0; md_op = 4'd0; md_use_d = 1'b0;
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL squashed_div_busy: got %b expected 0", busy); end
  endtask

  task automatic test_mtx;
    int n;
    issue(4'd1, 32'd7, 32'd9, 1'b1);
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL req_mult_busy: got %b expected 0", busy); end
    step(); step(); step(); step(); step();
    tests_run++; if (lo !== 32'd16) begin tests_failed++; $display("[TB] FAIL req_mult_lo: got %h expected 00000010", lo); end
    tests_run++; if (hi !== 32'd0) begin tests_failed++; $display("[TB] FAIL req_mult_hi: got %h expected 00000000", hi); end
    issue(4'd6, 32'h0000_1234, 32'h0, 1'b0);
    tests_run++; if (lo !== 32'h0000_1234) begin tests_failed++; $display("[TB] FAIL mtlo_lo: got %h expected 00001234", lo); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL mtlo_busy: got %b expected 0", busy); end
    issue(4'd5, 32'hCAFE_F00D, 32'h0, 1'b0);
    tests_run++; if (hi !== 32'hCAFE_F00D) begin tests_failed++; $display("[TB] FAIL mthi_hi: got %h expected cafef00d", hi); end
    issue(4'd15, 32'h1111_1111, 32'h2222_2222, 1'b0);
    issue(4'd0, 32'h3333_3333, 32'h4444_4444, 1'b0);
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL undef_op_busy: got %b expected 0", busy); end
    tests_run++; if ({hi, lo} !== {32'hCAFE_F00D, 32'h0000_1234}) begin tests_failed++; $display("[TB] FAIL undef_op_hilo: got %h expected cafef00d00001234", {hi, lo}); end
    issue(4'd1, 32'd2, 32'd3, 1'b0);
    issue(4'd3, 32'd10, 32'd3, 1'b0);
    wait_idle(n);
    tests_run++; if (n !== 4) begin tests_failed++; $display("[TB] FAIL start_while_busy_cycles: got %0d expected 4", n); end
    tests_run++; if ({hi, lo} !== {32'd0, 32'd6}) begin tests_failed++; $display("[TB] FAIL start_while_busy_hilo: got %h expected 0000000000000006", {hi, lo}); end
  endtask

  task automatic test_madd;
    int n;
    issue(4'd5, 32'h0, 32'h0, 1'b0);
    issue(4'd6, 32'hFFFF_FFFF, 32'h0, 1'b0);
    issue(4'd8, 32'd1, 32'd1, 1'b0);
    wait_idle(n);
`ifdef MDU_MADD_EN
    tests_run++; if (n !== 5) begin tests_failed++; $display("[TB] FAIL maddu_busy_cycles: got %0d expected 5", n); end
    tests_run++; if ({hi, lo} !== {32'd1, 32'd0}) begin tests_failed++; $display("[TB] FAIL maddu_hilo: got %h expected 0000000100000000", {hi, lo}); end
    issue(4'd7, 32'hFFFF_FFFF, 32'd1, 1'b0);
    wait_idle(n);
    tests_run++; if (n !== 5) begin tests_failed++; $display("[TB] FAIL madd_busy_cycles: got %0d expected 5", n); end
    tests_run++; if ({hi, lo} !== {32'd0, 32'hFFFF_FFFF}) begin tests_failed++; $display("[TB] FAIL madd_hilo: got %h expected 00000000ffffffff", {hi, lo}); end
`else
    tests_run++; if (n !== 0) begin tests_failed++; $display("[TB] FAIL maddu_disabled_busy: got %0d expected 0", n); end
    tests_run++; if ({hi, lo} !== {32'd0, 32'hFFFF_FFFF}) begin tests_failed++; $display("[TB] FAIL maddu_disabled_hilo: got %h expected 00000000ffffffff", {hi, lo}); end
    issue(4'd7, 32'hFFFF_FFFF, 32'd1, 1'b0);
    wait_idle(n);
    tests_run++; if (n !== 0) begin tests_failed++; $display("[TB] FAIL madd_disabled_busy: got %0d expected 0", n); end
    tests_run++; if ({hi, lo} !== {32'd0, 32'hFFFF_FFFF}) begin tests_failed++; $display("[TB] FAIL madd_disabled_hilo: got %h expected 00000000ffffffff", {hi, lo}); end
`endif
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_async_reset();
    test_mult();
    test_div();
    test_stall();
    test_mtx();
    test_madd();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
